// File: rtl/wfg_subcore_wishbone_regbank.sv
// Wishbone register bank for the multi-channel waveform subcore: byte-lane writes,
// shadowed per-channel SUBCYCLE/SYNC, enables, read-only status and sticky W1C interrupts.
module wfg_subcore_wishbone_regbank #(
  parameter int BUSW = 32,
  parameter int NCH  = 4,
  parameter int SUBW = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [BUSW/8-1:0]   wbs_sel_i,
  input  logic [BUSW-1:0]     wbs_dat_i,
  input  logic [BUSW-1:0]     wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [BUSW-1:0]     wbs_dat_o,
  input  logic [NCH-1:0]      cyc_done_i,
  input  logic [NCH-1:0]      evt_i,
  output logic [NCH*SUBW-1:0] cfg_subcycle_q_o,
  output logic [NCH*8-1:0]    cfg_sync_q_o,
  output logic [NCH-1:0]      ctrl_en_q_o,
  output logic                irq_o
);
  localparam int CFGW = SUBW + 8;

  localparam logic [5:0] IDX_CTRL   = 6'd0;
  localparam logic [5:0] IDX_STATUS = 6'd1;
  localparam logic [5:0] IDX_IRQ    = 6'd2;
  localparam logic [5:0] IDX_IRQ_EN = 6'd3;
  localparam logic [5:0] IDX_CFG0   = 6'd4;

  logic            ack_q;
  logic [BUSW-1:0] dat_q;
  logic [BUSW-1:0] rdata;
  logic [NCH-1:0]  en_q, en_d;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  irq_q, irq_d;
  logic [NCH-1:0]  irq_en_q, irq_en_d;
  logic            irq_out_q, irq_out_d;
  logic [CFGW-1:0] shadow_q   [NCH];
  logic [CFGW-1:0] shadow_d   [NCH];
  logic [SUBW-1:0] act_sub_q  [NCH];
  logic [SUBW-1:0] act_sub_d  [NCH];
  logic [7:0]      act_sync_q [NCH];
  logic [7:0]      act_sync_d [NCH];

  logic       accept, wr, rd;
  logic [5:0] widx;
  logic       unused_ok;

  // Masking with ~ack_q makes a held strobe alternate accept/ack cycles.
  assign accept    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr        = accept & wbs_we_i & (|wbs_sel_i);
  assign rd        = accept & ~wbs_we_i;
  assign widx      = wbs_adr_i[7:2];
  assign unused_ok = ^{wbs_adr_i[BUSW-1:8], wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    rdata = '0;
    case (widx)
      IDX_CTRL:   rdata[NCH-1:0] = en_q;
      IDX_STATUS: begin
        rdata[NCH-1:0] = en_q;
        rdata[8 +: NCH] = pend_q;
      end
      IDX_IRQ:    rdata[NCH-1:0] = irq_q;
      IDX_IRQ_EN: rdata[NCH-1:0] = irq_en_q;
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (widx == IDX_CFG0 + 6'(k)) rdata[CFGW-1:0] = shadow_q[k];
        end
      end
    endcase
  end

  always_comb begin
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    irq_d     = irq_q | evt_i;
    pend_d    = pend_q;
    irq_out_d = |(irq_q & irq_en_q);
    for (int k = 0; k < NCH; k++) begin
      shadow_d[k]   = shadow_q[k];
      act_sub_d[k]  = act_sub_q[k];
      act_sync_d[k] = act_sync_q[k];
    end

    if (wr) begin
      case (widx)
        IDX_CTRL: begin
          for (int i = 0; i < NCH; i++) if (wbs_sel_i[i/8]) en_d[i] = wbs_dat_i[i];
        end
        IDX_IRQ: begin
          // A clear loses against an event arriving in the same cycle.
          for (int i = 0; i < NCH; i++) begin
            if (wbs_sel_i[i/8] && wbs_dat_i[i] && !evt_i[i]) irq_d[i] = 1'b0;
          end
        end
        IDX_IRQ_EN: begin
          for (int i = 0; i < NCH; i++) if (wbs_sel_i[i/8]) irq_en_d[i] = wbs_dat_i[i];
        end
        default: ;
      endcase
    end

    for (int k = 0; k < NCH; k++) begin
      // Disabled channels apply immediately; enabled ones wait for a subcycle boundary.
      if (pend_q[k] && (!en_q[k] || cyc_done_i[k])) begin
        act_sub_d[k]  = shadow_q[k][8 +: SUBW];
        act_sync_d[k] = shadow_q[k][7:0];
        pend_d[k]     = 1'b0;
      end
      // A write in the same cycle keeps pend set so the new data waits for the next load.
      if (wr && widx == IDX_CFG0 + 6'(k)) begin
        for (int i = 0; i < CFGW; i++) if (wbs_sel_i[i/8]) shadow_d[k][i] = wbs_dat_i[i];
        pend_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      en_q      <= '0;
      pend_q    <= '0;
      irq_q     <= '0;
      irq_en_q  <= '0;
      irq_out_q <= 1'b0;
      // NOTE: these arrays are plain flop banks, not RAM, so they are reset like any other register.
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k]   <= '0;
        act_sub_q[k]  <= '0;
        act_sync_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      ack_q     <= accept;
      if (rd) dat_q <= rdata;
      en_q      <= en_d;
      pend_q    <= pend_d;
      irq_q     <= irq_d;
      irq_en_q  <= irq_en_d;
      irq_out_q <= irq_out_d;
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k]   <= shadow_d[k];
        act_sub_q[k]  <= act_sub_d[k];
        act_sync_q[k] <= act_sync_d[k];
      end
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign ctrl_en_q_o = en_q;
  assign irq_o       = irq_out_q;

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign cfg_subcycle_q_o[k*SUBW +: SUBW] = act_sub_q[k];
    assign cfg_sync_q_o[k*8 +: 8]           = act_sync_q[k];
  end

endmodule

// File: tb/tb_wfg_subcore_wishbone_regbank.sv
// Self-checking bench for wfg_subcore_wishbone_regbank: directed scenarios plus
// randomized traffic compared every cycle against a register-level reference model.
module tb_wfg_subcore_wishbone_regbank;
  localparam int NCH  = 4;
  localparam int SUBW = 16;
  localparam logic [31:0] CH_MASK  = (32'd1 << NCH) - 32'd1;
  localparam logic [31:0] CFG_MASK = (32'd1 << (SUBW + 8)) - 32'd1;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                stb   = 1'b0;
  logic                cyc   = 1'b0;
  logic                we    = 1'b0;
  logic [3:0]          sel   = '0;
  logic [31:0]         wdat  = '0;
  logic [31:0]         adr   = '0;
  logic [NCH-1:0]      cd    = '0;
  logic [NCH-1:0]      evt   = '0;
  logic                ack;
  logic [31:0]         rdat;
  logic [NCH*SUBW-1:0] sub_o;
  logic [NCH*8-1:0]    sync_o;
  logic [NCH-1:0]      en_o;
  logic                irq;

  wfg_subcore_wishbone_regbank #(.BUSW(32), .NCH(NCH), .SUBW(SUBW)) dut (
    .wb_clk_i         (clk),
    .wb_rst_ni        (rst_n),
    .wbs_stb_i        (stb),
    .wbs_cyc_i        (cyc),
    .wbs_we_i         (we),
    .wbs_sel_i        (sel),
    .wbs_dat_i        (wdat),
    .wbs_adr_i        (adr),
    .wbs_ack_o        (ack),
    .wbs_dat_o        (rdat),
    .cyc_done_i       (cd),
    .evt_i            (evt),
    .cfg_subcycle_q_o (sub_o),
    .cfg_sync_q_o     (sync_o),
    .ctrl_en_q_o      (en_o),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the programmer-visible registers as plain 32-bit words.
  logic            m_ack  = 1'b0;
  logic            m_irqo = 1'b0;
  logic [31:0]     m_dat  = '0;
  logic [31:0]     m_en   = '0;
  logic [31:0]     m_pend = '0;
  logic [31:0]     m_irq  = '0;
  logic [31:0]     m_ien  = '0;
  logic [31:0]     m_shadow [NCH];
  logic [SUBW-1:0] m_sub    [NCH];
  logic [7:0]      m_sync   [NCH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input int w);
    if (w == 0) return m_en;
    if (w == 1) return m_en | (m_pend << 8);
    if (w == 2) return m_irq;
    if (w == 3) return m_ien;
    if (w >= 4 && w < 4 + NCH) return m_shadow[w-4];
    return 32'h0;
  endfunction

  // Advances the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    logic        acc;
    int          w;
    logic [31:0] old_en, old_pend, old_irq, old_ien, evt32, cd32;
    logic [31:0] old_sh [NCH];
    if (!rst_n) begin
      m_ack = 1'b0; m_dat = '0; m_en = '0; m_pend = '0; m_irq = '0; m_ien = '0; m_irqo = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        m_shadow[k] = '0; m_sub[k] = '0; m_sync[k] = '0;
      end
      return;
    end
    w        = int'(adr[7:2]);
    acc      = stb && cyc && !m_ack;
    evt32    = 32'(evt);
    cd32     = 32'(cd);
    old_en   = m_en;
    old_pend = m_pend;
    old_irq  = m_irq;
    old_ien  = m_ien;
    for (int k = 0; k < NCH; k++) old_sh[k] = m_shadow[k];

    if (acc && !we) m_dat = mread(w);
    m_irqo = |(old_irq & old_ien);
    m_irq  = old_irq | evt32;
    for (int k = 0; k < NCH; k++) begin
      if (old_pend[k] && (!old_en[k] || cd32[k])) begin
        m_sub[k]  = old_sh[k][8 +: SUBW];
        m_sync[k] = old_sh[k][7:0];
        m_pend[k] = 1'b0;
      end
    end
    if (acc && we && sel != 4'b0000) begin
      if (w == 0) m_en = lane_merge(old_en, wdat, sel) & CH_MASK;
      else if (w == 2) m_irq = ((old_irq & ~lane_merge(32'h0, wdat, sel)) | evt32) & CH_MASK;
      else if (w == 3) m_ien = lane_merge(old_ien, wdat, sel) & CH_MASK;
      else if (w >= 4 && w < 4 + NCH) begin
        m_shadow[w-4] = lane_merge(old_sh[w-4], wdat, sel) & CFG_MASK;
        m_pend[w-4]   = 1'b1;
      end
    end
    m_ack = acc;
  endtask

  task automatic compare_all();
    logic [NCH*SUBW-1:0] exp_sub;
    logic [NCH*8-1:0]    exp_sync;
    for (int k = 0; k < NCH; k++) begin
      exp_sub[k*SUBW +: SUBW] = m_sub[k];
      exp_sync[k*8 +: 8]      = m_sync[k];
    end
    check("ack",      64'(ack),    64'(m_ack));
    check("dat_o",    64'(rdat),   64'(m_dat));
    check("en",       64'(en_o),   64'(m_en));
    check("irq_o",    64'(irq),    64'(m_irqo));
    check("subcycle", 64'(sub_o),  64'(exp_sub));
    check("sync",     64'(sync_o), 64'(exp_sync));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; wdat = d; sel = s; we = 1'b1; stb = 1'b1; cyc = 1'b1;
    tick();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; cd = '0; evt = '0;
    tick();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    adr = a; sel = 4'hF; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    tick();
    d = rdat;
    stb = 1'b0; cyc = 1'b0; cd = '0; evt = '0;
    tick();
  endtask

  initial begin
    logic [31:0] d;
    int          acks;
    int          idx;

    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = '0; m_sub[k] = '0; m_sync[k] = '0;
    end

    // Reset and defaults
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a <= 32'h2C; a += 4) begin
      wb_read(32'(a), d);
      check("rst_read", 64'(d), 64'h0);
    end
    check("rst_irq", 64'(irq), 64'h0);

    // Reset during an accept cycle drops the access
    adr = 32'h0; we = 1'b0; stb = 1'b1; cyc = 1'b1; rst_n = 1'b0;
    tick();
    check("rst_drop_ack", 64'(ack), 64'h0);
    stb = 1'b0; cyc = 1'b0; rst_n = 1'b1;
    tick();
    check("rst_drop_ack2", 64'(ack), 64'h0);

    // Byte lanes
    wb_write(32'h14, 32'h00AB_CD12, 4'b0011);
    wb_write(32'h14, 32'h00FF_0000, 4'b0100);
    wb_read(32'h14, d);
    check("lane_read", 64'(d), 64'h00FF_CD12);
    check("lane_sub1", 64'(sub_o[31:16]), 64'hFFCD);
    wb_write(32'h14, 32'hFFFF_FFFF, 4'b0000);
    wb_read(32'h14, d);
    check("sel0_noop", 64'(d), 64'h00FF_CD12);

    // Shadow while enabled
    wb_write(32'h00, 32'h0000_000F, 4'b0001);
    check("en_all", 64'(en_o), 64'hF);
    wb_write(32'h18, 32'h0012_3456, 4'hF);
    check("shadow_hold_sub2", 64'(sub_o[47:32]), 64'h0);
    wb_read(32'h04, d);
    check("status_pend2", 64'(d[10]), 64'h1);
    cd = 4'b0100;
    tick();
    cd = '0;
    check("shadow_load_sub2", 64'(sub_o[47:32]), 64'h1234);
    check("shadow_load_sync2", 64'(sync_o[23:16]), 64'h56);
    wb_read(32'h04, d);
    check("status_clr2", 64'(d[10]), 64'h0);

    // Write coincident with a boundary
    cd = 4'b0001;
    wb_write(32'h10, 32'h0000_0101, 4'hF);
    check("coinc_sub0", 64'(sub_o[15:0]), 64'h0);
    check("coinc_sync0", 64'(sync_o[7:0]), 64'h0);
    wb_read(32'h04, d);
    check("coinc_pend0", 64'(d[8]), 64'h1);
    cd = 4'b0001;
    tick();
    cd = '0;
    check("coinc_load_sub0", 64'(sub_o[15:0]), 64'h1);
    check("coinc_load_sync0", 64'(sync_o[7:0]), 64'h1);

    // IRQ: latency, set-wins, clear
    wb_write(32'h0C, 32'h0000_0002, 4'hF);
    evt = 4'b0010;
    tick();
    evt = '0;
    check("irq_lat1", 64'(irq), 64'h0);
    tick();
    check("irq_lat2", 64'(irq), 64'h1);
    evt = 4'b0010;
    wb_write(32'h08, 32'h0000_0002, 4'hF);
    wb_read(32'h08, d);
    check("irq_set_wins", 64'(d), 64'h2);
    wb_write(32'h08, 32'h0000_0002, 4'hF);
    check("irq_cleared", 64'(irq), 64'h0);

    // Unmapped addresses, STATUS write, back-to-back strobe
    wb_read(32'h20, d);
    check("unmapped_read", 64'(d), 64'h0);
    wb_write(32'h3C, 32'hFFFF_FFFF, 4'hF);
    wb_write(32'h04, 32'h0000_0000, 4'hF);
    wb_read(32'h00, d);
    check("ctrl_kept", 64'(d), 64'hF);
    wb_read(32'h04, d);
    check("status_kept", 64'(d), 64'hF);
    adr = 32'h0; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    repeat (6) begin
      tick();
      if (ack) acks++;
    end
    stb = 1'b0; cyc = 1'b0;
    tick();
    check("b2b_acks", 64'(acks), 64'd3);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idx   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3 + NCH));
      adr   = ($urandom & 32'hFFFF_FF03) | (32'(idx) << 2);
      wdat  = $urandom;
      sel   = 4'($urandom);
      we    = 1'($urandom);
      stb   = ($urandom_range(0, 9) < 6);
      cyc   = stb ? ($urandom_range(0, 7) != 0) : 1'($urandom);
      cd    = NCH'($urandom & $urandom);
      evt   = NCH'($urandom & $urandom & $urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; cd = '0; evt = '0; rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wfg_subcore_wishbone_regbank.md
Name: wfg_subcore_wishbone_regbank

Overview:
- Parametrised Wishbone register bank for the multi-channel waveform subcore.
- Provides NCH independent channels, each with its own SUBCYCLE/SYNC configuration, plus a global per-channel enable.
- Adds four things the single-channel bank lacks: byte-lane write masking, shadowed configuration that never changes mid-subcycle, a read-only status register, and a sticky write-1-to-clear interrupt register.
- Sits between the Wishbone interconnect and the NCH subcycle/sync generators.

Parameters:
- BUSW, 32, bus data/address width; only 32 is supported.
- NCH, 4, number of channels; legal range 1..8.
- SUBW, 16, SUBCYCLE field width; field occupies CFG bits [8+SUBW-1:8]; SUBW ≤ 24.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  BUSW/8  byte-lane selects.
- wbs_dat_i  in  BUSW  write data.
- wbs_adr_i  in  BUSW  byte address; bits [7:2] decoded, other bits ignored.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  BUSW  read data.
- cyc_done_i  in  NCH  per-channel one-cycle pulse at each subcycle boundary.
- evt_i  in  NCH  per-channel one-cycle event pulse (e.g. sync wrap).
- cfg_subcycle_q_o  out  NCH*SUBW  active SUBCYCLE per channel; channel k in slice [k*SUBW +: SUBW].
- cfg_sync_q_o  out  NCH*8  active SYNC per channel; channel k in slice [k*8 +: 8].
- ctrl_en_q_o  out  NCH  per-channel enable.
- irq_o  out  1  interrupt request, level.

Behaviour:
- Reset: while wb_rst_ni=0 at a clock edge, all registers and outputs go to 0: ack, dat_o, all CFG active and shadow values, pending flags, EN, IRQ, IRQ_EN, irq_o. Reset mid-transaction drops the transaction; no ack is issued for it.
- Access acceptance: an access is accepted in a cycle where stb & cyc & !ack.
  - wbs_ack_o=1 on the following cycle, for exactly one cycle.
  - With stb held, ack toggles, giving one access every two cycles.
  - Each access takes effect exactly once.
- Register map (byte offsets):
  - 0x00 CTRL, RW: EN[NCH-1:0].
  - 0x04 STATUS, RO: [NCH-1:0]=EN, [15:8]=pending-shadow flags for channels 0..NCH-1.
  - 0x08 IRQ, RW1C: sticky per-channel event flags [NCH-1:0].
  - 0x0C IRQ_EN, RW: [NCH-1:0].
  - 0x10+4k CFG_k for k<NCH, RW: SUBCYCLE [8+SUBW-1:8], SYNC [7:0].
- Unused bits and unmapped addresses: unused bits read 0. Unmapped addresses (including CFG_k with k≥NCH) are still acked; writes are ignored and reads return 0.
- Byte lanes: a write updates only the bytes whose wbs_sel_i bit is set. sel=0 is acked with no effect. STATUS ignores writes.
- Read data: wbs_dat_o is loaded at acceptance and held until the next accepted read.
  - CFG_k reads return the shadow value, i.e. the last written value.
- Shadowing, per channel:
  - A CFG_k write merges into shadow_k and sets pend_k.
  - Active is loaded from shadow when either:
    - EN_k=0, on the cycle after the write; or
    - EN_k=1, on the first cycle in which cyc_done_i[k]=1 and pend_k=1.
  - pend_k clears on that same load.
  - A write and cyc_done in the same cycle: the new data goes to shadow, pend stays set, and the new data is applied at the next boundary.
  - EN_k falling 1→0 with pend_k set: the load happens on the next cycle.
- Enable: ctrl_en_q_o updates one cycle after the CTRL write is accepted.
- IRQ:
  - evt_i[k] sets IRQ[k].
  - Writing 1 to IRQ[k] clears it; writing 0 has no effect.
  - Set and clear in the same cycle: set wins.
  - irq_o is registered: irq_o = |(IRQ & IRQ_EN), one cycle after IRQ or IRQ_EN changes.
- Ordering: no combinational path from Wishbone inputs to outputs.

Test Plan:
- Reset/default: hold wb_rst_ni=0 for 3 cycles, then read all addresses 0x00–0x2C → all data 0, ack one cycle after each accept, irq_o=0.
- Byte lanes: write CFG_1 0x00ABCD12 with sel=4'b0011, then 0x00FF0000 with sel=4'b0100 → readback 0x00FFCD12; channel-1 subcycle output 0xFFCD while EN_1=0.
- Shadow while enabled: EN=4'hF; write CFG_2=0x00123456 → outputs unchanged and STATUS[10]=1; pulse cyc_done_i[2] → next cycle subcycle_2=0x1234, sync_2=0x56, STATUS[10]=0.
- Write coincident with boundary: write CFG_0=0x00000101 in the same cycle as cyc_done_i[0] → active unchanged, pend_0 still 1; next cyc_done_i[0] → 0x01/0x01 applied.
- IRQ: IRQ_EN=4'h2; pulse evt_i[1] → irq_o=1 two cycles later; write IRQ=0x2 in the same cycle as another evt_i[1] → IRQ[1] stays 1; write IRQ=0x2 alone → irq_o=0.
- Unmapped and back-to-back: with NCH=4, read 0x20 → ack with 0; write 0x3C → no register changes; stb held for 6 cycles → exactly 3 acks.
